branch_tag_allocator: RTL and testbench



---
 rtl/branch_tag_allocator_pkg.sv | 22 ++
 rtl/branch_tag_allocator_picker.sv | 36 +++
 rtl/branch_tag_allocator.sv | 187 ++++++++++++++++++
 tb/tb_branch_tag_allocator.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/branch_tag_allocator_pkg.sv
// ---------------------------------------------------------------------------
// branch_tag_allocator_pkg
//   Shared branch-tag definitions (the sys_defs slice used by dispatch, the
//   branch stack and the tag allocator).
//   - `B_MASK_WIDTH : number of branch tags / branch stack entries
//   - B_MASK        : one-hot / mask vector over all branch tags
//   - BTAG_COUNT    : wide enough to hold 0..`B_MASK_WIDTH free tags
//   Optional build macros used by the allocator: BTAG_FREE_BYPASS_EN, DEBUG.
// ---------------------------------------------------------------------------
`ifndef B_MASK_WIDTH
`define B_MASK_WIDTH 4
`endif

package branch_tag_allocator_pkg;

  localparam int BMaskWidth = `B_MASK_WIDTH;
  localparam int BTagCountWidth = $clog2(BMaskWidth + 1);

  typedef logic [BMaskWidth-1:0]     B_MASK;
  typedef logic [BTagCountWidth-1:0] BTAG_COUNT;

endpackage

// File: rtl/branch_tag_allocator_picker.sv
// ---------------------------------------------------------------------------
// btag_picker
//   Returns the N_PICK lowest set bits of a free-tag vector, each as its own
//   one-hot vector, with a valid flag per output. Output k is the k-th
//   lowest free tag, so valid_o is monotone: once an output is invalid every
//   later output is invalid too.
//   Ports:
//     free_i  [WIDTH]          tags available for grant
//     pick_o  [N_PICK][WIDTH]  one-hot pick k (zero when not valid)
//     valid_o [N_PICK]         pick k exists
// ---------------------------------------------------------------------------
module btag_picker
  import branch_tag_allocator_pkg::*;
#(
  parameter int WIDTH  = BMaskWidth,
  parameter int N_PICK = 2
) (
  input  logic [WIDTH-1:0]             free_i,
  output logic [N_PICK-1:0][WIDTH-1:0] pick_o,
  output logic [N_PICK-1:0]            valid_o
);

  // Peel off the lowest set bit repeatedly; x & (~x + 1) isolates it.
  always_comb begin
    logic [WIDTH-1:0] remaining;
    remaining = free_i;
    pick_o    = '0;
    valid_o   = '0;
    for (int k = 0; k < N_PICK; k++) begin
      pick_o[k]  = remaining & (~remaining + WIDTH'(1));
      valid_o[k] = |remaining;
      remaining  = remaining & ~pick_o[k];
    end
  end

endmodule

// File: rtl/branch_tag_allocator.sv
// ---------------------------------------------------------------------------
// branch_tag_allocator
//   Grants one-hot branch tags to in-order dispatching branches, tracks which
//   tags are live and which tags are younger than each tag, retires a tag on
//   a correct resolve and squashes a tag plus all its younger tags on a
//   mispredict.
//   Ports:
//     clock, reset       system clock, synchronous active-high reset
//     alloc_req          per-slot tag request (slot 0 oldest)
//     alloc_gnt          per-slot grant this cycle
//     alloc_tag          per-slot one-hot tag (zero if not granted)
//     alloc_dep_mask     per-slot set of live tags older than the slot
//     resolve_valid      a branch resolves this cycle
//     resolve_tag        one-hot tag of the resolving branch
//     resolve_mispred    the resolving branch mispredicted
//     squash_mask        tags killed this cycle
//     live_mask          registered set of allocated tags
//     free_count         registered number of free tags
//     alloc_stall        some requesting slot was not granted
//   Build macros:
//     BTAG_FREE_BYPASS_EN  a tag freed by a correct resolve is grantable in
//                          the same cycle (otherwise only the next cycle)
//     DEBUG                enables consistency assertions
// ---------------------------------------------------------------------------
module branch_tag_allocator
  import branch_tag_allocator_pkg::*;
#(
  parameter int N_DISPATCH = 2,
  parameter int NUM_TAGS   = `B_MASK_WIDTH,
  localparam int CW        = $clog2(NUM_TAGS + 1)
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [N_DISPATCH-1:0]                alloc_req,
  output logic [N_DISPATCH-1:0]                alloc_gnt,
  output logic [N_DISPATCH-1:0][NUM_TAGS-1:0]  alloc_tag,
  output logic [N_DISPATCH-1:0][NUM_TAGS-1:0]  alloc_dep_mask,
  input  logic                                 resolve_valid,
  input  logic [NUM_TAGS-1:0]                  resolve_tag,
  input  logic                                 resolve_mispred,
  output logic [NUM_TAGS-1:0]                  squash_mask,
  output logic [NUM_TAGS-1:0]                  live_mask,
  output logic [CW-1:0]                        free_count,
  output logic                                 alloc_stall
);

  logic [NUM_TAGS-1:0]                 live_q, live_d;
  logic [NUM_TAGS-1:0][NUM_TAGS-1:0]   dep_q, dep_d;
  logic [CW-1:0]                       free_count_q, free_count_d;

  logic                                resolveHit;
  logic [NUM_TAGS-1:0]                 resolveYounger;
  logic [NUM_TAGS-1:0]                 correctFree;
  logic [NUM_TAGS-1:0]                 killMask;
  logic [NUM_TAGS-1:0]                 grantPool;
  logic                                grantEnable;
  logic [N_DISPATCH-1:0][NUM_TAGS-1:0] pickTag;
  logic [N_DISPATCH-1:0]               pickValid;

  // Decode the resolve against current state. The OR over rows tolerates a
  // non-one-hot tag structurally; legality is checked by the DEBUG assertion.
  always_comb begin
    resolveYounger = '0;
    for (int t = 0; t < NUM_TAGS; t++) begin
      if (resolve_tag[t]) resolveYounger = resolveYounger | dep_q[t];
    end
    resolveHit  = !reset && resolve_valid && |(resolve_tag & live_q);
    correctFree = (resolveHit && !resolve_mispred) ? resolve_tag : '0;
    killMask    = (resolveHit &&  resolve_mispred) ? (resolve_tag | resolveYounger) : '0;
    grantEnable = !reset && (killMask == '0);
  end

  // With the bypass, a correctly resolved tag is already back in the pool.
`ifdef BTAG_FREE_BYPASS_EN
  assign grantPool = ~live_q | correctFree;
`else
  assign grantPool = ~live_q;
`endif

  btag_picker #(
    .WIDTH  (NUM_TAGS),
    .N_PICK (N_DISPATCH)
  ) picker (
    .free_i  (grantPool),
    .pick_o  (pickTag),
    .valid_o (pickValid)
  );

  // In-order grant: the k-th requesting slot takes the k-th lowest free tag.
  // Because pick validity is monotone, a failed slot blocks all later
  // requesting slots automatically. The older set excludes a tag being
  // freed this cycle, so dependencies never point at a retiring tag.
  always_comb begin
    logic [NUM_TAGS-1:0] olderMask;
    int                  pickIdx;
    alloc_gnt      = '0;
    alloc_tag      = '0;
    alloc_dep_mask = '0;
    olderMask      = live_q & ~correctFree;
    pickIdx        = 0;
    for (int i = 0; i < N_DISPATCH; i++) begin
      if (alloc_req[i]) begin
        if (grantEnable && pickValid[pickIdx]) begin
          alloc_gnt[i]      = 1'b1;
          alloc_tag[i]      = pickTag[pickIdx];
          alloc_dep_mask[i] = olderMask;
          olderMask         = olderMask | pickTag[pickIdx];
        end
        pickIdx = pickIdx + 1;
      end
    end
  end

  assign squash_mask = killMask;
  assign alloc_stall = |(alloc_req & ~alloc_gnt);
  assign live_mask   = live_q;
  assign free_count  = free_count_q;

  // Next state: first retire/kill rows and columns, then add new grants.
  // A new tag clears its own row and becomes younger than every tag in its
  // dependency mask.
  always_comb begin
    logic [NUM_TAGS-1:0] clearMask;
    logic [CW-1:0]       liveCount;
    clearMask = correctFree | killMask;
    live_d    = live_q & ~clearMask;
    for (int t = 0; t < NUM_TAGS; t++) begin
      dep_d[t] = clearMask[t] ? '0 : (dep_q[t] & ~clearMask);
    end
    for (int i = 0; i < N_DISPATCH; i++) begin
      if (alloc_gnt[i]) begin
        live_d = live_d | alloc_tag[i];
        for (int t = 0; t < NUM_TAGS; t++) begin
          if (alloc_tag[i][t])      dep_d[t] = '0;
          if (alloc_dep_mask[i][t]) dep_d[t] = dep_d[t] | alloc_tag[i];
        end
      end
    end
    liveCount = '0;
    for (int t = 0; t < NUM_TAGS; t++) begin
      liveCount = liveCount + CW'(live_d[t]);
    end
    free_count_d = CW'(NUM_TAGS) - liveCount;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      live_q       <= '0;
      dep_q        <= '0;
      free_count_q <= CW'(NUM_TAGS);
    end else begin
      live_q       <= live_d;
      dep_q        <= dep_d;
      free_count_q <= free_count_d;
    end
  end

`ifdef DEBUG
  // Consistency checks on registered state and this cycle's grants.
  logic [CW-1:0] dbgLiveCount;
  always_comb begin
    dbgLiveCount = '0;
    for (int t = 0; t < NUM_TAGS; t++) begin
      dbgLiveCount = dbgLiveCount + CW'(live_q[t]);
    end
  end

  always @(posedge clock) begin
    if (!reset) begin
      assert (free_count_q == CW'(NUM_TAGS) - dbgLiveCount)
        else $error("free_count inconsistent with live mask");
      assert (!resolve_valid || $onehot(resolve_tag))
        else $error("resolve_tag not one-hot");
      for (int i = 0; i < N_DISPATCH; i++) begin
        assert ((alloc_tag[i] & live_q & ~correctFree) == '0)
          else $error("granted tag already live");
        for (int j = i + 1; j < N_DISPATCH; j++) begin
          assert ((alloc_tag[i] & alloc_tag[j]) == '0)
            else $error("tag granted twice");
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_tag_allocator.sv
// ---------------------------------------------------------------------------
// tb_branch_tag_allocator
//   Directed bench for branch_tag_allocator with 2 dispatch slots, 4 tags.
//   Inputs are driven 1 time unit after the rising edge; outputs are sampled
//   2 units later, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_branch_tag_allocator;

  logic            clock;
  logic            reset;
  logic [1:0]      allocReq;
  logic [1:0]      allocGnt;
  logic [1:0][3:0] allocTag;
  logic [1:0][3:0] allocDepMask;
  logic            resolveValid;
  logic [3:0]      resolveTag;
  logic            resolveMispred;
  logic [3:0]      squashMask;
  logic [3:0]      liveMask;
  logic [2:0]      freeCount;
  logic            allocStall;

  int errorCount;
  int checkCount;

  branch_tag_allocator #(
    .N_DISPATCH (2),
    .NUM_TAGS   (4)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .alloc_req       (allocReq),
    .alloc_gnt       (allocGnt),
    .alloc_tag       (allocTag),
    .alloc_dep_mask  (allocDepMask),
    .resolve_valid   (resolveValid),
    .resolve_tag     (resolveTag),
    .resolve_mispred (resolveMispred),
    .squash_mask     (squashMask),
    .live_mask       (liveMask),
    .free_count      (freeCount),
    .alloc_stall     (allocStall)
  );

  // Free-running clock, period 10.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", name, actual, expected);
    end
  endtask

  // Drive one cycle's inputs and let combinational outputs settle.
  task automatic applyStimulus(input logic [1:0] req, input logic rValid,
                               input logic [3:0] rTag, input logic rMis);
    allocReq       = req;
    resolveValid   = rValid;
    resolveTag     = rTag;
    resolveMispred = rMis;
    #2;
  endtask

  // Advance past the next rising edge and drop all requests.
  task automatic tick();
    @(posedge clock);
    #1;
    allocReq       = 2'b00;
    resolveValid   = 1'b0;
    resolveTag     = 4'b0000;
    resolveMispred = 1'b0;
  endtask

  initial begin
    errorCount     = 0;
    checkCount     = 0;
    reset          = 1'b1;
    allocReq       = 2'b00;
    resolveValid   = 1'b0;
    resolveTag     = 4'b0000;
    resolveMispred = 1'b0;

    // Reset: requests are ignored, state is empty.
    tick();
    tick();
    applyStimulus(2'b11, 1'b0, 4'b0000, 1'b0);
    checkOutput("reset_gnt", 32'(allocGnt), 32'h0);
    checkOutput("reset_live", 32'(liveMask), 32'h0);
    checkOutput("reset_free", 32'(freeCount), 32'd4);
    checkOutput("reset_squash", 32'(squashMask), 32'h0);
    tick();
    reset = 1'b0;

    // Two-slot allocation from empty.
    applyStimulus(2'b11, 1'b0, 4'b0000, 1'b0);
    checkOutput("a1_gnt", 32'(allocGnt), 32'h3);
    checkOutput("a1_tag0", 32'(allocTag[0]), 32'h1);
    checkOutput("a1_tag1", 32'(allocTag[1]), 32'h2);
    checkOutput("a1_dep1", 32'(allocDepMask[1]), 32'h1);
    checkOutput("a1_stall", 32'(allocStall), 32'h0);
    tick();
    checkOutput("a1_live", 32'(liveMask), 32'h3);
    checkOutput("a1_free", 32'(freeCount), 32'd2);

    // Fill remaining tags, then a full-stall request.
    applyStimulus(2'b11, 1'b0, 4'b0000, 1'b0);
    checkOutput("a2_tag0", 32'(allocTag[0]), 32'h4);
    checkOutput("a2_tag1", 32'(allocTag[1]), 32'h8);
    checkOutput("a2_dep0", 32'(allocDepMask[0]), 32'h3);
    checkOutput("a2_dep1", 32'(allocDepMask[1]), 32'h7);
    tick();
    applyStimulus(2'b01, 1'b0, 4'b0000, 1'b0);
    checkOutput("full_gnt", 32'(allocGnt), 32'h0);
    checkOutput("full_stall", 32'(allocStall), 32'h1);
    checkOutput("full_free", 32'(freeCount), 32'd0);
    checkOutput("full_live", 32'(liveMask), 32'hF);

    // Mispredict tag 1 kills 1,2,3.
    applyStimulus(2'b00, 1'b1, 4'b0010, 1'b1);
    checkOutput("mp1_squash", 32'(squashMask), 32'hE);
    tick();
    checkOutput("mp1_live", 32'(liveMask), 32'h1);
    checkOutput("mp1_free", 32'(freeCount), 32'd3);

    // Clear and test correct resolve followed by a lone mispredict.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    applyStimulus(2'b11, 1'b0, 4'b0000, 1'b0);
    tick();
    applyStimulus(2'b00, 1'b1, 4'b0001, 1'b0);
    checkOutput("cr_squash", 32'(squashMask), 32'h0);
    tick();
    checkOutput("cr_live", 32'(liveMask), 32'h2);
    checkOutput("cr_free", 32'(freeCount), 32'd3);
    applyStimulus(2'b00, 1'b1, 4'b0010, 1'b1);
    checkOutput("mp2_squash", 32'(squashMask), 32'h2);
    tick();
    checkOutput("mp2_live", 32'(liveMask), 32'h0);
    checkOutput("mp2_free", 32'(freeCount), 32'd4);

    // Fill all, then correct resolve of tag 0 with a same-cycle request.
    applyStimulus(2'b11, 1'b0, 4'b0000, 1'b0);
    tick();
    applyStimulus(2'b11, 1'b0, 4'b0000, 1'b0);
    tick();
    applyStimulus(2'b01, 1'b1, 4'b0001, 1'b0);
`ifdef BTAG_FREE_BYPASS_EN
    checkOutput("byp_gnt", 32'(allocGnt), 32'h1);
    checkOutput("byp_tag0", 32'(allocTag[0]), 32'h1);
    checkOutput("byp_dep0", 32'(allocDepMask[0]), 32'hE);
    checkOutput("byp_stall", 32'(allocStall), 32'h0);
    tick();
    checkOutput("byp_live", 32'(liveMask), 32'hF);
`else
    checkOutput("nobyp_gnt", 32'(allocGnt), 32'h0);
    checkOutput("nobyp_stall", 32'(allocStall), 32'h1);
    tick();
    checkOutput("nobyp_live", 32'(liveMask), 32'hE);
    checkOutput("nobyp_free", 32'(freeCount), 32'd1);
    applyStimulus(2'b01, 1'b0, 4'b0000, 1'b0);
    checkOutput("nobyp_gnt2", 32'(allocGnt), 32'h1);
    checkOutput("nobyp_tag2", 32'(allocTag[0]), 32'h1);
    checkOutput("nobyp_dep2", 32'(allocDepMask[0]), 32'hE);
    tick();
    checkOutput("nobyp_live2", 32'(liveMask), 32'hF);
`endif

    // Tag 0 is now the youngest: mispredict kills it alone and blocks grants.
    applyStimulus(2'b11, 1'b1, 4'b0001, 1'b1);
    checkOutput("mp3_gnt", 32'(allocGnt), 32'h0);
    checkOutput("mp3_squash", 32'(squashMask), 32'h1);
    checkOutput("mp3_stall", 32'(allocStall), 32'h1);
    tick();
    checkOutput("mp3_live", 32'(liveMask), 32'hE);
    checkOutput("mp3_free", 32'(freeCount), 32'd1);

    // Resolve of a tag that is not live has no effect.
    applyStimulus(2'b00, 1'b1, 4'b0001, 1'b1);
    checkOutput("dead_squash", 32'(squashMask), 32'h0);
    tick();
    checkOutput("dead_live", 32'(liveMask), 32'hE);

    // Reset mid-sequence dominates a pending request and resolve.
    reset = 1'b1;
    applyStimulus(2'b11, 1'b1, 4'b0010, 1'b1);
    checkOutput("rst2_gnt", 32'(allocGnt), 32'h0);
    checkOutput("rst2_squash", 32'(squashMask), 32'h0);
    @(posedge clock);
    #1;
    checkOutput("rst2_live", 32'(liveMask), 32'h0);
    checkOutput("rst2_free", 32'(freeCount), 32'd4);
    reset = 1'b0;
    allocReq     = 2'b00;
    resolveValid = 1'b0;
    applyStimulus(2'b01, 1'b0, 4'b0000, 1'b0);
    checkOutput("post_tag0", 32'(allocTag[0]), 32'h1);
    tick();

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
